// File: rtl/sp_fifo_pkg.sv
// Shared types and defaults for the sp_fifo read-side adapter.
// Holds the state enum, default sizes and the skid buffer depth.
package sp_fifo_pkg;

  localparam int DEPTH_DEF   = 16;
  localparam int DW_DEF      = 8;
  localparam int BUF_ENTRIES = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_ERR
  } rd_state_e;

endpackage

// File: rtl/rd_skid_buf3.sv
// Three-entry circular skid buffer with registered head.
// Ports: clk, rst (async high), push/push_data, pop, head, entries.
module rd_skid_buf3
  import sp_fifo_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [1:0]    entries
);

  logic [DW-1:0] mem_q [BUF_ENTRIES];
  logic [1:0]    wp_q, rp_q, cnt_q;
  logic          pop_ok;

  function automatic logic [1:0] inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // A pop from an empty buffer is ignored.
  assign pop_ok  = pop && (cnt_q != 2'd0);
  assign head    = mem_q[rp_q];
  assign entries = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_ENTRIES; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      // Push into a full buffer is only legal alongside a pop;
      // the slot written is the one the head is leaving.
      if (push) begin
        mem_q[wp_q] <= push_data;
        wp_q        <= inc(wp_q);
      end
      if (pop_ok) rp_q <= inc(rp_q);
      cnt_q <= cnt_q + 2'(push) - 2'(pop_ok);
    end
  end

endmodule

// File: rtl/sp_fifo_rd_adapter.sv
// Read-side adapter for a flagless sp_fifo: tracks occupancy, issues reads,
// presents data as valid/ready. Optional stats: SP_FIFO_RD_STATS_EN.
module sp_fifo_rd_adapter
  import sp_fifo_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  parameter  int DW    = DW_DEF,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fifo_wr_en,
  output logic          fifo_rd_en,
  input  logic [DW-1:0] fifo_dout,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  input  logic          m_ready,
  output logic [CW-1:0] occupancy,
  output logic          overflow,
`ifdef SP_FIFO_RD_STATS_EN
  output logic [15:0]   pop_cnt,
  output logic [CW-1:0] max_occ,
`endif
  input  logic          clr_err
);

  rd_state_e     state_q, state_d;
  logic [CW-1:0] occ_q, occ_d;
  logic          ovf_q, ovf_d;
  logic          infl_q;
  logic [1:0]    entries;
  logic          ovf_ev, clr_go, pop;

  assign ovf_ev = fifo_wr_en && (occ_q == CW'(DEPTH));
  assign clr_go = (state_q == S_ERR) && clr_err;
  assign pop    = m_valid && m_ready;

  // Counts words in flight plus buffered so a read is only issued when
  // its word is guaranteed a slot; m_ready never reaches this path.
  assign fifo_rd_en = (state_q == S_RUN) && (occ_q != '0) &&
                      (({1'b0, entries} + {2'b0, infl_q}) < 3'(BUF_ENTRIES));

  assign m_valid   = (entries != 2'd0);
  assign occupancy = occ_q;
  assign overflow  = ovf_q;

  always_comb begin
    occ_d   = occ_q;
    ovf_d   = ovf_q;
    state_d = state_q;
    if (clr_go) begin
      occ_d   = '0;
      ovf_d   = 1'b0;
      state_d = S_IDLE;
    end else if (ovf_ev) begin
      occ_d   = CW'(DEPTH);
      ovf_d   = 1'b1;
      state_d = S_ERR;
    end else begin
      occ_d = occ_q + CW'(fifo_wr_en) - CW'(fifo_rd_en);
      // Next-state uses the updated count so reads start the cycle
      // right after the first write lands.
      unique case (state_q)
        S_IDLE:  if (occ_d != '0) state_d = S_RUN;
        S_RUN:   if (occ_d == '0) state_d = S_IDLE;
        S_ERR:   state_d = S_ERR;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      occ_q   <= '0;
      ovf_q   <= 1'b0;
      infl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      ovf_q   <= ovf_d;
      infl_q  <= fifo_rd_en;
    end
  end

  rd_skid_buf3 #(.DW(DW)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (infl_q),
    .push_data (fifo_dout),
    .pop       (pop),
    .head      (m_data),
    .entries   (entries)
  );

`ifdef SP_FIFO_RD_STATS_EN
  logic [15:0]   pop_cnt_q;
  logic [CW-1:0] max_occ_q;

  assign pop_cnt = pop_cnt_q;
  assign max_occ = max_occ_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pop_cnt_q <= '0;
      max_occ_q <= '0;
    end else begin
      if (pop && (pop_cnt_q != 16'hFFFF)) pop_cnt_q <= pop_cnt_q + 16'd1;
      if (clr_go)                max_occ_q <= '0;
      else if (occ_d > max_occ_q) max_occ_q <= occ_d;
    end
  end
`endif

endmodule

// File: tb/tb_sp_fifo_rd_adapter.sv
// Self-checking bench for sp_fifo_rd_adapter with a flagless FIFO model
// and a queue-based reference of occupancy, reads and the output stream.
module tb_sp_fifo_rd_adapter;

  localparam int DEPTH = 16;
  localparam int DW    = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_wr_en = 1'b0;
  logic          m_ready = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] din = '0;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_dout;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [CW-1:0] occupancy;
  logic          overflow;
`ifdef SP_FIFO_RD_STATS_EN
  logic [15:0]   pop_cnt;
  logic [CW-1:0] max_occ;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sp_fifo_rd_adapter #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_wr_en (fifo_wr_en),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .occupancy  (occupancy),
    .overflow   (overflow),
`ifdef SP_FIFO_RD_STATS_EN
    .pop_cnt    (pop_cnt),
    .max_occ    (max_occ),
`endif
    .clr_err    (clr_err)
  );

  // Flagless upstream FIFO with 1-cycle registered read data.
  logic [DW-1:0] mem [DEPTH];
  logic [3:0]    wp = '0, rp = '0;
  logic          flush = 1'b0;

  always @(posedge clk) begin
    if (rst || flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (fifo_wr_en) begin
        mem[wp] <= din;
        wp <= wp + 4'd1;
      end
      if (fifo_rd_en) begin
        fifo_dout <= mem[rp];
        rp <= rp + 4'd1;
      end
    end
  end

  // Reference model.
  int            m_occ;
  bit            m_err, m_ovf, m_infl;
  logic [DW-1:0] m_infl_d;
  logic [DW-1:0] wq[$];
  logic [DW-1:0] bq[$];
  int            m_pops, m_max;
  logic [DW-1:0] got[$];

  function automatic bit exp_rd();
    return !m_err && (m_occ > 0) && ((bq.size() + int'(m_infl)) < 3);
  endfunction

  task automatic model_reset();
    m_occ = 0; m_err = 0; m_ovf = 0; m_infl = 0; m_infl_d = '0;
    wq.delete(); bq.delete(); m_pops = 0; m_max = 0;
  endtask

  task automatic model_edge(input bit wr, input bit rdy, input bit clr,
                            input logic [DW-1:0] d);
    bit rd, pp;
    rd = exp_rd();
    pp = (bq.size() > 0) && rdy;
    if (m_err && clr) begin
      m_occ = 0; m_err = 0; m_ovf = 0; wq.delete(); m_max = 0;
    end else if (wr && m_occ == DEPTH) begin
      m_occ = DEPTH; m_err = 1; m_ovf = 1;
    end else begin
      m_occ = m_occ + int'(wr) - int'(rd);
      if (wr) wq.push_back(d);
    end
    if (m_occ > m_max) m_max = m_occ;
    if (pp) begin
      void'(bq.pop_front());
      if (m_pops < 16'hFFFF) m_pops++;
    end
    if (m_infl) bq.push_back(m_infl_d);
    m_infl = rd;
    if (rd && wq.size() > 0) m_infl_d = wq.pop_front();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("rd_en", int'(fifo_rd_en), int'(exp_rd()));
    chk("m_valid", int'(m_valid), int'(bq.size() > 0));
    if (bq.size() > 0) chk("m_data", int'(m_data), int'(bq[0]));
    chk("occupancy", int'(occupancy), m_occ);
    chk("overflow", int'(overflow), int'(m_ovf));
`ifdef SP_FIFO_RD_STATS_EN
    chk("pop_cnt", int'(pop_cnt), m_pops);
    chk("max_occ", int'(max_occ), m_max);
`endif
  endtask

  // Inputs change just after a negedge; model advances at the posedge.
  task automatic step(input bit wr, input bit rdy, input bit clr,
                      input logic [DW-1:0] d);
    fifo_wr_en = wr; m_ready = rdy; clr_err = clr; din = d;
    flush = clr && m_err;
    if (m_valid && m_ready) got.push_back(m_data);
    @(posedge clk);
    model_edge(wr, rdy, clr, d);
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fifo_wr_en = 0; m_ready = 0; clr_err = 0; flush = 0;
    model_reset();
    got.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    compare();
  endtask

  initial begin
    int nrd;
    int rpct;
    bit wr, clr;

    // Reset state
    do_reset();
    chk("rst_occ", int'(occupancy), 0);
    chk("rst_valid", int'(m_valid), 0);
    chk("rst_data", int'(m_data), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_rd", int'(fifo_rd_en), 0);

    // Back-to-back 0..15 with m_ready=1
    step(1, 1, 0, 8'd0);
    chk("t1_first_rd", int'(fifo_rd_en), 1);
    step(1, 1, 0, 8'd1);
    chk("t1_valid_e2", int'(m_valid), 0);
    step(1, 1, 0, 8'd2);
    chk("t1_valid_e3", int'(m_valid), 1);
    chk("t1_data_e3", int'(m_data), 0);
    for (int k = 3; k < 16; k++) step(1, 1, 0, 8'(k));
    for (int k = 0; k < 6; k++) step(0, 1, 0, 8'd0);
    chk("t1_count", got.size(), 16);
    for (int k = 0; k < got.size(); k++) chk("t1_order", int'(got[k]), k);
    chk("t1_occ", int'(occupancy), 0);
    chk("t1_rd_idle", int'(fifo_rd_en), 0);

    // Backpressure: exactly 3 reads outstanding
    do_reset();
    nrd = 0;
    for (int k = 0; k < 16; k++) begin
      step(1, 0, 0, 8'(k));
      if (fifo_rd_en) nrd++;
    end
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 8'd0);
      if (fifo_rd_en) nrd++;
    end
    chk("t2_reads", nrd, 3);
    chk("t2_occ", int'(occupancy), 13);
    chk("t2_data", int'(m_data), 0);
    got.delete();
    for (int k = 0; k < 24; k++) step(0, 1, 0, 8'd0);
    chk("t2_count", got.size(), 16);
    for (int k = 0; k < got.size(); k++) chk("t2_order", int'(got[k]), k);

    // Overflow on the 20th write
    do_reset();
    for (int k = 0; k < 19; k++) step(1, 0, 0, 8'(k));
    chk("t3_occ19", int'(occupancy), 16);
    chk("t3_ovf19", int'(overflow), 0);
    step(1, 0, 0, 8'd19);
    chk("t3_ovf", int'(overflow), 1);
    chk("t3_rd", int'(fifo_rd_en), 0);
    chk("t3_occ", int'(occupancy), 16);
    step(0, 0, 0, 8'd0);
    chk("t3_rd_err", int'(fifo_rd_en), 0);

    // Clear error; buffered words still drain
    got.delete();
    step(0, 1, 1, 8'd0);
    for (int k = 0; k < 5; k++) step(0, 1, 0, 8'd0);
    chk("t4_count", got.size(), 3);
    for (int k = 0; k < got.size(); k++) chk("t4_order", int'(got[k]), k);
    chk("t4_ovf", int'(overflow), 0);
    chk("t4_occ", int'(occupancy), 0);

    // Streaming: occupancy settles at 1
    do_reset();
    for (int k = 0; k < 30; k++) step(1, 1, 0, 8'($urandom));
    chk("t5_occ", int'(occupancy), 1);
    chk("t5_ovf", int'(overflow), 0);
    chk("t5_valid", int'(m_valid), 1);

    // Asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    chk("t6_valid", int'(m_valid), 0);
    chk("t6_rd", int'(fifo_rd_en), 0);
    chk("t6_occ", int'(occupancy), 0);
`ifdef SP_FIFO_RD_STATS_EN
    chk("t6_pop_cnt", int'(pop_cnt), 0);
`endif
    model_reset();
    fifo_wr_en = 0; m_ready = 0; clr_err = 0;
    @(negedge clk);
    rst = 1'b0;
    compare();

    // Randomized traffic with overflow/clear recovery
    rpct = 50;
    for (int k = 0; k < 1500; k++) begin
      if (k % 100 == 0) rpct = ($urandom_range(0, 2) == 0) ? 0 :
                               (($urandom_range(0, 1) == 0) ? 40 : 95);
      if (m_err) begin
        wr  = 0;
        clr = ($urandom_range(0, 3) == 0);
      end else begin
        wr  = ($urandom_range(0, 99) < 60);
        clr = ($urandom_range(0, 49) == 0);
      end
      step(wr, $urandom_range(0, 99) < rpct, clr, 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
